// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package inst_fetch_ctrl_pkg;

  localparam int CPU_WIDTH           = 32;
  localparam int INST_MEM_ADDR_WIDTH = 10;

  localparam logic [CPU_WIDTH-1:0] PC_STEP    = 32'd4;
  localparam logic [CPU_WIDTH-1:0] ALIGN_MASK = {{(CPU_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  // Instructions are word aligned; the two low address bits are dropped.
  function automatic logic [CPU_WIDTH-1:0] align_pc(input logic [CPU_WIDTH-1:0] pc);
    return pc & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_fifo.sv
// Synchronous fetch buffer: head is read combinationally from storage,
// push and pop may coincide even when full, flush empties it in one edge.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ZERO = '0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointer and occupancy bookkeeping; flush takes precedence over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Storage carries data only, so it is left without reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == ZERO);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: issues sequential reads to a 1-cycle memory,
// tags each read with an epoch so redirects discard stale returns, and
// buffers returned words for decode behind a valid/ready handshake.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic [CPU_WIDTH-1:0] imem_rdata,
  output logic                 if_valid,
  output logic [CPU_WIDTH-1:0] if_pc,
  output logic [CPU_WIDTH-1:0] if_inst,
  input  logic                 id_ready
);

  localparam int          CW      = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  fetch_state_t         state;
  logic [CPU_WIDTH-1:0] fetch_pc;
  logic                 epoch;
  logic                 inflight;
  logic                 inflight_epoch;
  logic [CPU_WIDTH-1:0] inflight_pc;

  logic [CW:0]              count;
  logic [CW:0]              occupancy;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     issue;
  logic                     flush;
  logic [2*CPU_WIDTH-1:0]   head;

  // Issue/accept decisions. A redirect cycle neither issues nor counts a pop;
  // occupancy includes the word still in flight so the buffer never overflows.
  always_comb begin
    pop       = !empty && id_ready && !redirect_valid;
    occupancy = count + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    issue     = (state != ST_BOOT) && !redirect_valid && (occupancy < DEPTH_V);
    push      = inflight && (inflight_epoch == epoch);
    flush     = redirect_valid && (state != ST_BOOT);
  end

  // Control FSM with fetch PC and epoch; redirect outranks sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      fetch_pc <= RESET_PC;
      epoch    <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
          if (redirect_valid) fetch_pc <= align_pc(redirect_pc);
        end
        default: begin
          if (redirect_valid) begin
            state    <= ST_FLUSH;
            epoch    <= ~epoch;
            fetch_pc <= align_pc(redirect_pc);
          end else begin
            state <= ST_RUN;
            if (issue) fetch_pc <= fetch_pc + PC_STEP;
          end
        end
      endcase
    end
  end

  // In-flight tracking: one outstanding read, tagged with the issuing epoch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_epoch <= epoch;
    end
  end

  // PC of the outstanding read travels with its data into the buffer.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc <= fetch_pc;
  end

  fetch_fifo #(
    .WIDTH (2*CPU_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({inflight_pc, imem_rdata}),
    .rdata (head),
    .empty (empty),
    .count (count)
  );

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign if_valid  = !empty;
  assign if_pc     = empty ? '0 : head[2*CPU_WIDTH-1:CPU_WIDTH];
  assign if_inst   = empty ? '0 : head[CPU_WIDTH-1:0];

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a scoreboard of expected PCs.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int n_iss;

  logic [31:0] exp_q[$];
  int          acc_cyc_q[$];

  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc   = '0;
  logic [31:0] prev_inst = '0;

  inst_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Scoreboard on accepted words, hold stability, and buffer invariants.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n === 1'b1 && if_valid === 1'b1 && id_ready === 1'b1 && redirect_valid === 1'b0) begin
      acc_cnt++;
      acc_cyc_q.push_back(cyc);
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_accept: observed pc %h expected none", if_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check32("accept_pc", if_pc, e);
        check32("accept_inst", if_inst, mem_word(e));
      end
    end
    if (rst_n === 1'b1 && prev_hold) begin
      check1("hold_valid", if_valid, 1'b1);
      check32("hold_pc", if_pc, prev_pc);
      check32("hold_inst", if_inst, prev_inst);
    end
    if (rst_n === 1'b1) begin
      check1("no_push_when_full",
             dut.u_fifo.push && (dut.u_fifo.count == 2'd2) && !dut.u_fifo.pop && !dut.u_fifo.flush,
             1'b0);
      check1("no_pop_when_empty", dut.u_fifo.pop && dut.u_fifo.empty, 1'b0);
    end
    prev_hold = (rst_n === 1'b1) && if_valid && !id_ready && !redirect_valid;
    prev_pc   = if_pc;
    prev_inst = if_inst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let decode accept n words, then drop id_ready before another can go.
  task automatic wait_acc(input int n);
    int target;
    target = acc_cnt + n;
    for (int i = 0; i < 50 && acc_cnt < target; i++) step();
    check1("wait_acc_budget", acc_cnt >= target, 1'b1);
    id_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    step();
    step();
    @(negedge clk);
    check1("rst_if_valid", if_valid, 1'b0);
    check1("rst_imem_req", imem_req, 1'b0);
    check32("rst_if_pc", if_pc, 32'h0);
    check32("rst_if_inst", if_inst, 32'h0);

    // Test 1: streaming from reset with decode always ready.
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check1("boot_no_req", imem_req, 1'b0);
    step();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    acc_cyc_q.delete();
    @(negedge clk);
    check1("t1_first_req", imem_req, 1'b1);
    check32("t1_first_addr", imem_addr, 32'h0);
    wait_acc(3);
    check32("t1_consec_a", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'd1);
    check32("t1_consec_b", 32'(acc_cyc_q[2] - acc_cyc_q[1]), 32'd1);
    check32("t1_drained", 32'(exp_q.size()), 32'd0);

    // Test 2: decode stalled from the start.
    id_ready = 1'b0;
    do_reset();
    n_iss = 0;
    repeat (6) begin
      @(negedge clk);
      if (imem_req) n_iss++;
    end
    check1("t2_at_most_two", n_iss <= 2, 1'b1);
    check1("t2_valid", if_valid, 1'b1);
    check32("t2_pc_head", if_pc, 32'h0);
    step();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    id_ready = 1'b1;
    wait_acc(3);
    check32("t2_drained", 32'(exp_q.size()), 32'd0);

    // Test 3: redirect while 0x8 is in flight.
    do_reset();
    repeat (5) step();
    exp_q.push_back(32'h0);
    id_ready = 1'b1;
    wait_acc(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    check1("t3_no_issue_redirect", imem_req, 1'b0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check1("t3_flush_empty", if_valid, 1'b0);
    check1("t3_flush_req", imem_req, 1'b1);
    check32("t3_flush_addr", imem_addr, 32'h100);
    step();
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    id_ready = 1'b1;
    wait_acc(2);
    check32("t3_drained", 32'(exp_q.size()), 32'd0);

    // Test 4: back-to-back redirects, last one wins.
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check1("t4_req", imem_req, 1'b1);
    check32("t4_addr", imem_addr, 32'h300);
    step();
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h304);
    id_ready = 1'b1;
    wait_acc(2);
    check32("t4_drained", 32'(exp_q.size()), 32'd0);

    // Test 5: misaligned redirect target and PC wrap.
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check32("t5_aligned_addr", imem_addr, 32'h100);
    step();
    exp_q.push_back(32'h100);
    id_ready = 1'b1;
    wait_acc(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check32("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    id_ready = 1'b1;
    wait_acc(3);
    check32("t5_drained", 32'(exp_q.size()), 32'd0);

    // Test 6: reset pulse in the middle of a stream.
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    step();
    redirect_valid = 1'b0;
    step();
    exp_q.push_back(32'h400);
    exp_q.push_back(32'h404);
    id_ready = 1'b1;
    wait_acc(2);
    check32("t6_pre_drained", 32'(exp_q.size()), 32'd0);
    id_ready = 1'b1;
    rst_n    = 1'b0;
    @(negedge clk);
    check1("t6_rst_valid", if_valid, 1'b0);
    check1("t6_rst_req", imem_req, 1'b0);
    check32("t6_rst_pc", if_pc, 32'h0);
    step();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    rst_n = 1'b1;
    @(negedge clk);
    check1("t6_boot_no_req", imem_req, 1'b0);
    step();
    @(negedge clk);
    check1("t6_restart_req", imem_req, 1'b1);
    check32("t6_restart_addr", imem_addr, 32'h0);
    wait_acc(3);
    check32("t6_drained", 32'(exp_q.size()), 32'd0);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
